// File: rtl/window_issuer.sv
// ---------------------------------------------------------------------------
// window_issuer
// Transmit side of the arithmetic core operand port. It turns a raster pixel
// stream into 3x3 windows, issues one window per en pulse, holds the kernel,
// bias and mode settings steady toward the core, and waits out the core
// latency before it reports that the job has finished.
//
// Optional feature macro: ISSUER_STRIDE2_EN
//   defined   : only windows whose top-left (row, col) are both even are issued
//   undefined : stride 1, every complete window is issued
//   The pixel stream and the job timing are the same in both builds.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   cfg_we, cfg_*         configuration write, accepted in IDLE/DONE only
//   start                 1-cycle job start pulse, accepted in IDLE only
//   pix_in/valid/ready    raster pixel handshake, ready only while RUN
//   in                    3x3 window, cell k = 3*dr+dc, cell 0 = top-left
//   weight/bias/bound_level/step   mirror the configuration registers
//   en                    1-cycle window valid
//   en_relu/en_mp         configuration value while RUN/DRAIN, 0 otherwise
//   busy                  state != IDLE
//   done                  1-cycle pulse at the end of the job
// ---------------------------------------------------------------------------
module window_issuer #(
  parameter int cell_bit  = 8,
  parameter int N_cell    = 9,
  parameter int biasport  = 16,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int DRAIN_CYC = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [cell_bit*N_cell-1:0] cfg_weight,
  input  logic [biasport-1:0]        cfg_bias,
  input  logic [1:0]                 cfg_bound,
  input  logic [2:0]                 cfg_step,
  input  logic                       cfg_relu,
  input  logic                       cfg_mp,
  input  logic                       start,
  input  logic [cell_bit-1:0]        pix_in,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic [cell_bit*N_cell-1:0] in,
  output logic [cell_bit*N_cell-1:0] weight,
  output logic [biasport-1:0]        bias,
  output logic [1:0]                 bound_level,
  output logic [2:0]                 step,
  output logic                       en,
  output logic                       en_relu,
  output logic                       en_mp,
  output logic                       busy,
  output logic                       done
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam int WB = cell_bit * N_cell;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // configuration registers
  logic [WB-1:0]       r_weight;
  logic [biasport-1:0] r_bias;
  logic [1:0]          r_bound;
  logic [2:0]          r_step;
  logic                r_relu;
  logic                r_mp;

  // position of the next pixel to be accepted
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [DW-1:0] r_drain;

  // line buffers: r_lb0 holds row r-1, r_lb1 holds row r-2 at each column
  logic [cell_bit-1:0] r_lb0 [IMG_W];
  logic [cell_bit-1:0] r_lb1 [IMG_W];
  logic [WB-1:0]       r_win;

  // registered outputs
  logic [WB-1:0] r_in;
  logic          r_en;
  logic          r_en_relu;
  logic          r_en_mp;
  logic          r_busy;
  logic          r_done;
  logic          r_pix_ready;

  logic                  w_cfg_ok;
  logic                  w_start;
  logic                  w_xfer;
  logic                  w_last;
  logic                  w_stride_ok;
  logic                  w_issue;
  logic                  w_relu_nxt;
  logic                  w_mp_nxt;
  logic [3*cell_bit-1:0] w_col_new;
  logic [WB-1:0]         w_win_nxt;

  assign w_cfg_ok = cfg_we & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_start  = start & (r_state == S_IDLE);
  assign w_xfer   = pix_valid & (r_state == S_RUN);
  assign w_last   = w_xfer & (r_row == RW'(IMG_H - 1)) & (r_col == CW'(IMG_W - 1));

`ifdef ISSUER_STRIDE2_EN
  // (r-2) and (c-2) are even exactly when r and c are even
  assign w_stride_ok = ~r_row[0] & ~r_col[0];
`else
  assign w_stride_ok = 1'b1;
`endif

  // a pixel with r>=2 and c>=2 is the bottom-right cell of a complete window
  assign w_issue = w_xfer & (r_row >= RW'(2)) & (r_col >= CW'(2)) & w_stride_ok;

  // the core must see a configuration written together with start
  assign w_relu_nxt = w_cfg_ok ? cfg_relu : r_relu;
  assign w_mp_nxt   = w_cfg_ok ? cfg_mp : r_mp;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_RUN;
        else         w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DRAIN;
        else        w_state_nxt = S_RUN;
      end
      S_DRAIN: begin
        if (r_drain == DW'(DRAIN_CYC - 1)) w_state_nxt = S_DONE;
        else                               w_state_nxt = S_DRAIN;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // new window: each row shifts left by one cell, the new column enters at dc=2
  always_comb begin
    w_win_nxt = '0;
    w_col_new = {pix_in, r_lb0[r_col], r_lb1[r_col]};
    for (int dr = 0; dr < 3; dr++) begin
      w_win_nxt[cell_bit*(3*dr)   +: cell_bit] = r_win[cell_bit*(3*dr+1) +: cell_bit];
      w_win_nxt[cell_bit*(3*dr+1) +: cell_bit] = r_win[cell_bit*(3*dr+2) +: cell_bit];
      w_win_nxt[cell_bit*(3*dr+2) +: cell_bit] = w_col_new[cell_bit*dr +: cell_bit];
    end
  end

  // configuration registers, writable only while no job is in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_weight <= '0;
      r_bias   <= '0;
      r_bound  <= 2'd0;
      r_step   <= 3'd0;
      r_relu   <= 1'b0;
      r_mp     <= 1'b0;
    end else if (w_cfg_ok) begin
      r_weight <= cfg_weight;
      r_bias   <= cfg_bias;
      r_bound  <= cfg_bound;
      r_step   <= cfg_step;
      r_relu   <= cfg_relu;
      r_mp     <= cfg_mp;
    end
  end

  // raster position counters, rewound at every job start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_xfer) begin
      if (r_col == CW'(IMG_W - 1)) begin
        r_col <= '0;
        if (r_row == RW'(IMG_H - 1)) r_row <= '0;
        else                         r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // cycles spent in DRAIN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drain <= '0;
    end else if (r_state == S_DRAIN) begin
      r_drain <= r_drain + DW'(1);
    end else begin
      r_drain <= '0;
    end
  end

  // line buffers and shift window; contents are always overwritten before use
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb0[r_col] <= pix_in;
      r_win        <= w_win_nxt;
    end
  end

  // registered outputs toward the core and the pixel source
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in        <= '0;
      r_en        <= 1'b0;
      r_en_relu   <= 1'b0;
      r_en_mp     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pix_ready <= 1'b0;
    end else begin
      r_en        <= w_issue;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      r_pix_ready <= (w_state_nxt == S_RUN);
      if ((w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN)) begin
        r_en_relu <= w_relu_nxt;
        r_en_mp   <= w_mp_nxt;
      end else begin
        r_en_relu <= 1'b0;
        r_en_mp   <= 1'b0;
      end
      // in keeps the last window between pulses
      if (w_issue) r_in <= w_win_nxt;
    end
  end

  assign pix_ready   = r_pix_ready;
  assign in          = r_in;
  assign weight      = r_weight;
  assign bias        = r_bias;
  assign bound_level = r_bound;
  assign step        = r_step;
  assign en          = r_en;
  assign en_relu     = r_en_relu;
  assign en_mp       = r_en_mp;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_window_issuer.sv
// ---------------------------------------------------------------------------
// tb_window_issuer
// Scoreboard bench for window_issuer. Each job's expected windows are derived
// from the image by direct (row, col) arithmetic and queued before the pixels
// are sent; a negedge monitor pops and compares on every en pulse.
// ---------------------------------------------------------------------------
module tb_window_issuer;

  localparam int CB   = 8;
  localparam int NC   = 9;
  localparam int BP   = 16;
  localparam int W    = 8;
  localparam int H    = 8;
  localparam int NPIX = W * H;
  localparam int WB   = CB * NC;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_we;
  logic [WB-1:0] cfg_weight;
  logic [BP-1:0] cfg_bias;
  logic [1:0]    cfg_bound;
  logic [2:0]    cfg_step;
  logic          cfg_relu;
  logic          cfg_mp;
  logic          start;
  logic [CB-1:0] pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic [WB-1:0] dut_in;
  logic [WB-1:0] weight;
  logic [BP-1:0] bias;
  logic [1:0]    bound_level;
  logic [2:0]    step;
  logic          en;
  logic          en_relu;
  logic          en_mp;
  logic          busy;
  logic          done;

  window_issuer dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_weight(cfg_weight),
    .cfg_bias(cfg_bias), .cfg_bound(cfg_bound), .cfg_step(cfg_step),
    .cfg_relu(cfg_relu), .cfg_mp(cfg_mp), .start(start), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .in(dut_in), .weight(weight),
    .bias(bias), .bound_level(bound_level), .step(step), .en(en),
    .en_relu(en_relu), .en_mp(en_mp), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [WB-1:0] exp_q[$];
  int            exp_n;
  int            en_count;
  int            first_en_cyc;
  int            done_cyc;
  bit            done_seen;
  int            p18_cyc;
  logic          exp_relu;
  logic          exp_mp;
  logic [CB-1:0] img [NPIX];

  task automatic check_w(input string name, input logic [WB-1:0] act, input logic [WB-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_i(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // monitor: every en pulse consumes one expected window
  always @(negedge clk) begin
    if (reset) begin
      if (en) begin
        if (en_count == 0) first_en_cyc = cyc;
        en_count++;
        if (exp_q.size() == 0) begin
          check_i("extra_window", int'(en), 0);
        end else begin
          check_w("window", dut_in, exp_q.pop_front());
        end
        check_i("en_relu", int'(en_relu), int'(exp_relu));
        check_i("en_mp", int'(en_mp), int'(exp_mp));
      end
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
    end
  end

  // reference: every 3x3 window of the image in raster order of its top-left
  task automatic build_job(input bit random_img);
    logic [WB-1:0] w;
    bit            keep;
    for (int i = 0; i < NPIX; i++) img[i] = random_img ? CB'($urandom) : CB'(i);
    exp_q.delete();
    exp_n = 0;
    for (int r0 = 0; r0 <= H - 3; r0++) begin
      for (int c0 = 0; c0 <= W - 3; c0++) begin
`ifdef ISSUER_STRIDE2_EN
        keep = (r0 % 2 == 0) && (c0 % 2 == 0);
`else
        keep = 1'b1;
`endif
        if (keep) begin
          w = '0;
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
              w[CB*(3*dr+dc) +: CB] = img[(r0+dr)*W + c0 + dc];
          exp_q.push_back(w);
          exp_n++;
        end
      end
    end
  endtask

  task automatic configure(input logic [BP-1:0] b, input logic relu, input logic mp);
    cfg_we     = 1'b1;
    cfg_weight = {NC{8'h01}};
    cfg_bias   = b;
    cfg_bound  = 2'd2;
    cfg_step   = 3'd5;
    cfg_relu   = relu;
    cfg_mp     = mp;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check_w("cfg_weight_out", weight, {NC{8'h01}});
    check_i("cfg_bias_out", int'(bias), int'(b));
    check_i("cfg_bound_out", int'(bound_level), 2);
    check_i("cfg_step_out", int'(step), 5);
    exp_relu = relu;
    exp_mp   = mp;
  endtask

  task automatic start_job();
    en_count  = 0;
    done_seen = 1'b0;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random valid
  task automatic send_image(input int mode, input int poke_at, input int abort_after,
                            output int last_acc, output bit aborted);
    int idx;
    int budget;
    bit acc;
    idx = 0; budget = 0; aborted = 1'b0; last_acc = 0;
    while (idx < NPIX) begin
      pix_in = img[idx];
      case (mode)
        0:       pix_valid = 1'b1;
        1:       pix_valid = (budget % 2 == 0);
        default: pix_valid = 1'($urandom_range(0, 1));
      endcase
      if (idx == poke_at) begin
        start    = 1'b1;
        cfg_we   = 1'b1;
        cfg_bias = 16'd7;
      end
      @(negedge clk);
      acc = pix_valid && pix_ready;
      if (acc) last_acc = cyc;
      if (acc && idx == 18) p18_cyc = cyc;
      @(posedge clk); #1;
      start  = 1'b0;
      cfg_we = 1'b0;
      if (acc) idx++;
      budget++;
      if (budget > 2000) begin
        check_i("pixel_accept_timeout", idx, NPIX);
        break;
      end
      if (abort_after > 0 && en_count >= abort_after) begin
        aborted = 1'b1;
        break;
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic finish_job(input int last_acc);
    for (int i = 0; i < 50 && !done_seen; i++) begin
      @(posedge clk); #1;
    end
    check_i("done_seen", int'(done_seen), 1);
    check_i("done_timing", done_cyc, last_acc + 4);
    check_i("window_count", en_count, exp_n);
    check_i("windows_left", exp_q.size(), 0);
    check_i("first_en_cycle", first_en_cyc, p18_cyc + 1);
    @(posedge clk); #1;
    check_i("idle_after_done", int'(busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_i({tag, "_en"}, int'(en), 0);
    check_i({tag, "_busy"}, int'(busy), 0);
    check_i({tag, "_pix_ready"}, int'(pix_ready), 0);
    check_i({tag, "_done"}, int'(done), 0);
    check_i({tag, "_relu_mp"}, int'({en_relu, en_mp}), 0);
    check_w({tag, "_in"}, dut_in, '0);
    check_w({tag, "_weight"}, weight, '0);
    check_i({tag, "_bias"}, int'(bias), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

  initial begin
    int la;
    bit ab;
    reset = 1'b0; cfg_we = 1'b0; cfg_weight = '0; cfg_bias = '0; cfg_bound = 2'd0;
    cfg_step = 3'd0; cfg_relu = 1'b0; cfg_mp = 1'b0; start = 1'b0;
    pix_in = '0; pix_valid = 1'b0;
    exp_relu = 1'b0; exp_mp = 1'b0; en_count = 0; p18_cyc = 0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_i("idle_busy", int'(busy), 0);
    check_i("idle_ready", int'(pix_ready), 0);
    check_i("idle_no_en", en_count, 0);

    // ramp image, back-to-back pixels
    configure(16'hFFFB, 1'b1, 1'b0);
    build_job(1'b0);
    start_job();
    send_image(0, -1, 0, la, ab);
    finish_job(la);

    // same image, pix_valid every other cycle
    build_job(1'b0);
    start_job();
    send_image(1, -1, 0, la, ab);
    finish_job(la);

    // cfg write and start during RUN must be ignored
    build_job(1'b0);
    start_job();
    send_image(0, 20, 0, la, ab);
    check_i("bias_held_in_run", int'(bias), 16'hFFFB);
    finish_job(la);
    check_i("bias_held_after", int'(bias), 16'hFFFB);

    // asynchronous abort after the 10th window
    build_job(1'b0);
    start_job();
    send_image(0, -1, 10, la, ab);
    check_i("abort_reached", int'(ab), 1);
    reset = 1'b0;
    #2;
    check_all_zero("abort");
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    configure(16'hFFFB, 1'b0, 1'b1);
    build_job(1'b0);
    start_job();
    send_image(0, -1, 0, la, ab);
    finish_job(la);

    // random images, random valid, random modes
    for (int j = 0; j < 3; j++) begin
      configure(BP'($urandom), 1'($urandom), 1'($urandom));
      build_job(1'b1);
      start_job();
      send_image(2, -1, 0, la, ab);
      finish_job(la);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
